// File: rtl/i2c_target_regif_pkg.sv
// Shared types and constants for the I2C register-interface target.
// Holds the FSM state encoding, the ACK/NACK bus levels and the byte/word widths.
package i2c_target_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        PTR,
        PTR_ACK,
        WMSB,
        WMSB_ACK,
        WLSB,
        WLSB_ACK,
        RMSB,
        RMSB_MACK,
        RLSB,
        RLSB_MACK,
        WAIT
    } state_t;

endpackage

// File: rtl/i2c_target_regif_if.sv
// Register-file side of the I2C target: single-cycle strobes out, read data back.
// reg_rdata is sampled exactly one clk after reg_rd_en is high; reg_addr/reg_wdata are valid only with a strobe.
interface i2c_target_regif_if;
    import i2c_target_pkg::*;

    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [BYTE_W-1:0] reg_addr;
    logic [WORD_W-1:0] reg_wdata;
    logic [WORD_W-1:0] reg_rdata;

    modport master (
        output reg_wr_en,
        output reg_rd_en,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_wr_en,
        input  reg_rd_en,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata
    );

endinterface

// File: rtl/i2c_target_regif_line_filter.sv
// Synchronizes and debounces the raw SCL/SDA pins, then flags SCL edges and START/STOP.
// A level must hold for FILTER_LEN consecutive synchronized samples before it is accepted.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    // Bit 0 carries SCL, bit 1 carries SDA; the bus idles high.
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       filt_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       upd;

    always_comb begin
        upd = '0;
        for (int i = 0; i < 2; i++) begin
            upd[i] = (sync_q[i] != filt_q[i]) && (cnt_q[i] == CNT_W'(FILTER_LEN - 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= 2'b11;
            sync_q   <= 2'b11;
            filt_q   <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            meta_q <= {sda_i, scl_i};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (upd[i]) begin
                    filt_q[i] <= sync_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign sda_o      = filt_q[1];
    assign scl_rise_o = upd[0] &  sync_q[0];
    assign scl_fall_o = upd[0] & ~sync_q[0];
    // SDA moving while the accepted SCL level is high is a bus condition, not data.
    assign start_o    = upd[1] & ~sync_q[1] & filt_q[0];
    assign stop_o     = upd[1] &  sync_q[1] & filt_q[0];

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target decoding 7-bit address / 8-bit pointer / 16-bit data transactions into
// single-cycle register-file strobes, with auto-incrementing pointer for bursts.
module i2c_target_regif
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h48,
    parameter int         FILTER_LEN = 3,
    parameter int         HOLD_CYC   = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   scl_in,
    input  logic   sda_in,
    output logic   sda_oe,
    output logic   busy,
    i2c_target_regif_if.master reg_bus,
    output state_t dbg_state_o
);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    logic sda_f, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_o      (sda_f),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d, ptr_q, ptr_d, msb_q, msb_d, addr_q, addr_d;
    logic [WORD_W-1:0] tx_q, tx_d, wdata_q, wdata_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rw_q, rw_d, busy_q, busy_d, oe_q, oe_d;
    logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d, fetch_q, fetch_d;
    logic [BYTE_W-1:0] rx_byte;
    logic [3:0]        tx_idx;
    logic              oe_want;

    assign rx_byte = {shift_q[BYTE_W-2:0], sda_f};
    assign tx_idx  = {state_q == RMSB, ~bit_cnt_q[2:0]};

    // Level SDA should settle to once the post-fall hold time has elapsed.
    always_comb begin
        oe_want = 1'b0;
        case (state_q)
            DEV_ACK, PTR_ACK, WMSB_ACK, WLSB_ACK: oe_want = 1'b1;
            RMSB, RLSB:                           oe_want = ~tx_q[tx_idx];
            default:                              oe_want = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        msb_d     = msb_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        wdata_d   = wdata_q;
        hold_d    = hold_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        oe_d      = oe_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        fetch_d   = rd_en_q;

        if (fetch_q) tx_d = reg_bus.reg_rdata;

        if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HOLD_W'(1)) oe_d = oe_want;
        end

        if (start_det) begin
            state_d   = DEV;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            hold_d    = '0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            hold_d    = '0;
            busy_d    = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                DEV, PTR, WMSB, WLSB: begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        case (state_q)
                            DEV: begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = DEV_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = rx_byte[0];
                                    rd_en_d = rx_byte[0];
                                    addr_d  = ptr_q;
                                end else begin
                                    state_d = WAIT;
                                end
                            end
                            PTR: begin
                                ptr_d   = rx_byte;
                                state_d = PTR_ACK;
                            end
                            WMSB: begin
                                msb_d   = rx_byte;
                                state_d = WMSB_ACK;
                            end
                            default: begin
                                wr_en_d = 1'b1;
                                addr_d  = ptr_q;
                                wdata_d = {msb_q, rx_byte};
                                ptr_d   = ptr_q + 8'd1;
                                state_d = WLSB_ACK;
                            end
                        endcase
                    end
                end
                RMSB, RLSB: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) state_d = (state_q == RMSB) ? RMSB_MACK : RLSB_MACK;
                end
                RMSB_MACK, RLSB_MACK: begin
                    bit_cnt_d = 4'd9;
                    if (sda_f == NACK) begin
                        state_d = WAIT;
                        busy_d  = 1'b0;
                    end else if (state_q == RLSB_MACK) begin
                        ptr_d   = ptr_q + 8'd1;
                        addr_d  = ptr_q + 8'd1;
                        rd_en_d = 1'b1;
                    end
                end
                DEV_ACK, PTR_ACK, WMSB_ACK, WLSB_ACK: bit_cnt_d = 4'd9;
                default: ;
            endcase
        end else if (scl_fall) begin
            hold_d = HOLD_W'(HOLD_CYC);
            // The fall ending the 9th clock hands the bus to the next byte phase.
            if (bit_cnt_q == 4'd9) begin
                bit_cnt_d = '0;
                case (state_q)
                    DEV_ACK:   state_d = rw_q ? RMSB : PTR;
                    PTR_ACK:   state_d = WMSB;
                    WMSB_ACK:  state_d = WLSB;
                    WLSB_ACK:  state_d = WMSB;
                    RMSB_MACK: state_d = RLSB;
                    RLSB_MACK: state_d = RMSB;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            msb_q     <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            wdata_q   <= '0;
            hold_q    <= '0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            fetch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            msb_q     <= msb_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            wdata_q   <= wdata_d;
            hold_q    <= hold_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            oe_q      <= oe_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            fetch_q   <= fetch_d;
        end
    end

    assign sda_oe            = oe_q;
    assign busy              = busy_q;
    assign dbg_state_o       = state_q;
    assign reg_bus.reg_wr_en = wr_en_q;
    assign reg_bus.reg_rd_en = rd_en_q;
    assign reg_bus.reg_addr  = addr_q;
    assign reg_bus.reg_wdata = wdata_q;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: bit-banged controller, register-file responder,
// strobe scoreboard and an array/pointer reference model of the register map.
module tb_i2c_target_regif;
    import i2c_target_pkg::*;

    localparam logic [6:0] DEV = 7'h48;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic   scl_drv = 1'b1;
    logic   sda_drv = 1'b1;
    logic   sda_oe, busy, sda_line;
    state_t dbg_state;

    assign sda_line = sda_drv & ~sda_oe;

    i2c_target_regif_if bus_if ();

    i2c_target_regif #(.DEV_ADDR(DEV), .FILTER_LEN(3), .HOLD_CYC(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scl_in      (scl_drv),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .busy        (busy),
        .reg_bus     (bus_if),
        .dbg_state_o (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model + register file ----------------
    logic [15:0] regfile [256];
    logic [15:0] ref_mem [256];
    logic [7:0]  ref_ptr = 8'h00;
    logic [15:0] wbuf [4];

    logic       rd_pend = 1'b0;
    logic [7:0] rd_addr_l;
    always @(negedge clk) begin
        if (bus_if.reg_wr_en) regfile[bus_if.reg_addr] = bus_if.reg_wdata;
        // Data is only valid in the single cycle the target is meant to sample it.
        if (rd_pend) begin
            bus_if.reg_rdata = regfile[rd_addr_l];
            rd_pend = 1'b0;
        end else begin
            bus_if.reg_rdata = 16'($urandom);
        end
        if (bus_if.reg_rd_en) begin
            rd_pend   = 1'b1;
            rd_addr_l = bus_if.reg_addr;
        end
    end

    // Strobe scoreboard entry: {wr, rd, addr, wdata-or-zero}
    logic [25:0] exp_q[$];
    logic [25:0] sb_got;
    always @(negedge clk) begin
        if (reset_n && (bus_if.reg_wr_en || bus_if.reg_rd_en)) begin
            sb_got = {bus_if.reg_wr_en, bus_if.reg_rd_en, bus_if.reg_addr,
                      bus_if.reg_wr_en ? bus_if.reg_wdata : 16'h0000};
            if (exp_q.size() == 0) check_eq("strobe_extra", 32'(sb_got), 32'h0);
            else                   check_eq("strobe", 32'(sb_got), 32'(exp_q.pop_front()));
        end
    end

    int   oe_viol = 0;
    logic oe_prev = 1'b0;
    always @(negedge clk) begin
        if (sda_oe !== oe_prev && scl_drv) oe_viol++;
        oe_prev = sda_oe;
    end

    // ---------------- bus driver tasks ----------------
    logic glitch_arm = 1'b0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        wait_clk(8); sda_drv = 1'b1;
        wait_clk(8); scl_drv = 1'b1;
        wait_clk(16); sda_drv = 1'b0;
        wait_clk(16); scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(8); sda_drv = 1'b0;
        wait_clk(8); scl_drv = 1'b1;
        wait_clk(16); sda_drv = 1'b1;
        wait_clk(16);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(3);
        if (glitch_arm) begin
            scl_drv = 1'b1; wait_clk(1); scl_drv = 1'b0;
            glitch_arm = 1'b0;
            wait_clk(4);
        end else begin
            wait_clk(5);
        end
        sda_drv = b;
        wait_clk(8); scl_drv = 1'b1;
        wait_clk(16); scl_drv = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(8); sda_drv = 1'b1;
        wait_clk(8); scl_drv = 1'b1;
        wait_clk(8); b = sda_line;
        wait_clk(8); scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(mack);
    endtask

    // ---------------- transaction-level model ----------------
    task automatic txn_write(input logic [7:0] p, input int n);
        logic ack;
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        check_eq("dev_ack_w", ack, ACK);
        check_eq("busy_set_w", busy, 1);
        write_byte(p, ack);
        check_eq("ptr_ack", ack, ACK);
        ref_ptr = p;
        for (int i = 0; i < n; i++) begin
            ref_mem[ref_ptr] = wbuf[i];
            exp_q.push_back({2'b10, ref_ptr, wbuf[i]});
            ref_ptr = ref_ptr + 8'd1;
            write_byte(wbuf[i][15:8], ack);
            check_eq("msb_ack", ack, ACK);
            write_byte(wbuf[i][7:0], ack);
            check_eq("lsb_ack", ack, ACK);
        end
        bus_stop();
        check_eq("busy_clr_stop", busy, 0);
        check_eq("wr_strobes_left", exp_q.size(), 0);
    endtask

    task automatic txn_read(input int n, input bit set_ptr, input logic [7:0] p);
        logic ack;
        logic [7:0]  b_hi, b_lo;
        logic [15:0] exp_w;
        bus_start();
        if (set_ptr) begin
            write_byte({DEV, 1'b0}, ack);
            check_eq("dev_ack_rw", ack, ACK);
            write_byte(p, ack);
            check_eq("ptr_ack_r", ack, ACK);
            ref_ptr = p;
            bus_start();
        end
        exp_q.push_back({2'b01, ref_ptr, 16'h0000});
        write_byte({DEV, 1'b1}, ack);
        check_eq("dev_ack_r", ack, ACK);
        for (int i = 0; i < n; i++) begin
            exp_w = ref_mem[ref_ptr];
            read_byte(b_hi, ACK);
            check_eq("rd_msb", b_hi, exp_w[15:8]);
            if (i != n - 1) exp_q.push_back({2'b01, ref_ptr + 8'd1, 16'h0000});
            read_byte(b_lo, (i == n - 1) ? NACK : ACK);
            check_eq("rd_lsb", b_lo, exp_w[7:0]);
            if (i != n - 1) ref_ptr = ref_ptr + 8'd1;
        end
        check_eq("busy_clr_nack", busy, 0);
        bus_stop();
        check_eq("rd_strobes_left", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ack;
        logic [15:0] v;
        logic [7:0]  p;
        int          n;

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            regfile[i] = v;
            ref_mem[i] = v;
        end
        wait_clk(5);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_en", bus_if.reg_wr_en, 0);
        check_eq("rst_rd_en", bus_if.reg_rd_en, 0);
        check_eq("rst_addr", bus_if.reg_addr, 0);
        check_eq("rst_wdata", bus_if.reg_wdata, 0);
        check_eq("rst_state", dbg_state, IDLE);
        reset_n = 1'b1;
        wait_clk(20);

        // single write, then a wrapping burst
        wbuf[0] = 16'h0300;
        txn_write(8'h0D, 1);
        wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
        txn_write(8'hFF, 2);
        check_eq("ptr_wrap_model", ref_ptr, 8'h01);

        // random read with fixed register contents
        regfile[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
        regfile[8'h11] = 16'h0042; ref_mem[8'h11] = 16'h0042;
        txn_read(2, 1'b1, 8'h10);

        // wrong device address is ignored, next addressed START accepted
        bus_start();
        write_byte({7'h49, 1'b0}, ack);
        check_eq("wrong_addr_nack", ack, NACK);
        check_eq("wrong_addr_busy", busy, 0);
        write_byte(8'hA5, ack);
        check_eq("wait_ignores", ack, NACK);
        bus_stop();
        wbuf[0] = 16'($urandom);
        txn_write(8'h20, 1);

        // STOP after only the MSB: no write, pointer kept
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h30, ack);
        ref_ptr = 8'h30;
        write_byte(8'h55, ack);
        bus_stop();
        txn_read(1, 1'b0, 8'h00);

        // repeated START in the middle of the LSB: no write
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h31, ack);
        ref_ptr = 8'h31;
        write_byte(8'h66, ack);
        for (int i = 7; i >= 4; i--) write_bit(1'($urandom));
        txn_read(1, 1'b0, 8'h00);

        // one-clk SCL glitch must not count as a bit
        glitch_arm = 1'b1;
        wbuf[0] = 16'($urandom);
        txn_write(8'h40, 1);
        txn_read(1, 1'b1, 8'h40);

        // randomized write bursts read back through the random-read sequence
        for (int t = 0; t < 6; t++) begin
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            txn_write(p, n);
            txn_read(n, 1'b1, p);
        end

        // asynchronous reset while the target is pulling SDA during a read
        wbuf[0] = 16'h00FF;
        txn_write(8'h50, 1);
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h50, ack);
        bus_start();
        exp_q.push_back({2'b01, 8'h50, 16'h0000});
        write_byte({DEV, 1'b1}, ack);
        for (int k = 0; k < 40 && !sda_oe; k++) wait_clk(1);
        check_eq("oe_driving_before_rst", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check_eq("oe_async_clear", sda_oe, 0);
        check_eq("busy_async_clear", busy, 0);
        wait_clk(4);
        reset_n = 1'b1;
        ref_ptr = 8'h00;
        bus_stop();
        txn_read(1, 1'b0, 8'h00);

        check_eq("oe_while_scl_high", oe_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
